mult_control_unit: RTL and testbench

//   Moore FSM that sequences datapath2 (32x32 shift-add multiplier) through one full

---
 rtl/mult_control_unit.sv | 152 +++++++++++++++
 tb/tb_mult_control_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mult_control_unit.sv
// mult_control_unit
//   Moore FSM that steps a 32x32 shift-add multiplier datapath through one
//   complete multiply. It also keeps its own iteration count and cross-checks
//   the datapath's less32 flag against that count.
//
// Ports
//   clk     in   rising-edge system clock
//   rst     in   synchronous, active-high reset
//   start   in   request a multiply (sampled only in IDLE)
//   abort   in   cancel the multiply in flight (no done is produced)
//   write   in   datapath: product[0]=1, an add cycle is needed
//   less32  in   datapath: datapath counter < WIDTH
//   dp_rst  out  load operands, clear product high half and counter
//   add     out  product[63:32] += multiplicand
//   shr     out  shift product (with carry) right by one
//   incr    out  datapath counter += 1
//   busy    out  high from INIT through the final CHECK
//   done    out  one-cycle pulse: the result is valid
//   err     out  sticky: less32 disagreed with the internal count
module mult_control_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  input  logic write,
  input  logic less32,
  output logic dp_rst,
  output logic add,
  output logic shr,
  output logic incr,
  output logic busy,
  output logic done,
  output logic err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_CHECK,
    S_ADD,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] WIDTH_C  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ITER_MAX = '1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic             err_q, err_d;
  logic             mism;

  logic dp_rst_q, dp_rst_d;
  logic add_q, add_d;
  logic shr_q, shr_d;
  logic incr_q, incr_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    err_d   = err_q;
    mism    = less32 ^ (iter_q < WIDTH_C);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_INIT;
          iter_d  = '0;
          err_d   = 1'b0;
        end
      end
      S_INIT:  state_d = S_CHECK;
      S_CHECK: begin
        if (mism) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (!less32) begin
          state_d = S_DONE;
        end else if (write) begin
          state_d = S_ADD;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_ADD:   state_d = S_SHIFT;
      S_SHIFT: begin
        state_d = S_CHECK;
        if (iter_q != ITER_MAX) begin
          iter_d = iter_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort overrides whatever the case above decided, including a pending
    // err set, so err keeps its previous value.
    if (abort && (state_q != S_IDLE) && (state_q != S_DONE)) begin
      state_d = S_IDLE;
      iter_d  = iter_q;
      err_d   = err_q;
    end

    // Outputs are decoded from the next state and registered, so each output
    // flop reflects exactly the state register during the following cycle.
    dp_rst_d = (state_d == S_INIT);
    add_d    = (state_d == S_ADD);
    shr_d    = (state_d == S_SHIFT);
    incr_d   = (state_d == S_SHIFT);
    busy_d   = (state_d == S_INIT) || (state_d == S_CHECK) ||
               (state_d == S_ADD)  || (state_d == S_SHIFT);
    done_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      iter_q   <= '0;
      err_q    <= 1'b0;
      dp_rst_q <= 1'b0;
      add_q    <= 1'b0;
      shr_q    <= 1'b0;
      incr_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      iter_q   <= iter_d;
      err_q    <= err_d;
      dp_rst_q <= dp_rst_d;
      add_q    <= add_d;
      shr_q    <= shr_d;
      incr_q   <= incr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign dp_rst = dp_rst_q;
  assign add    = add_q;
  assign shr    = shr_q;
  assign incr   = incr_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_mult_control_unit.sv
// tb_mult_control_unit
//   Drives mult_control_unit with a behavioural model of the shift-add
//   datapath (supplies write/less32, accumulates the product) and compares
//   the run against arithmetic expectations: done cycle = 3 + 2*WIDTH +
//   popcount(multiplier), add count = popcount, product = a*b.
module tb_mult_control_unit;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst, start, abort, write, less32;
  logic dp_rst, add, shr, incr, busy, done, err;

  always #5 clk = ~clk;

  mult_control_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .write(write), .less32(less32),
    .dp_rst(dp_rst), .add(add), .shr(shr), .incr(incr),
    .busy(busy), .done(done), .err(err)
  );

  // Datapath model
  logic [31:0] mcand = '0, mplier = '0;
  logic [63:0] dp_prod = '0;
  logic        dp_c = 1'b0;
  int          dp_cnt = 0;
  int          force_iter = -1;

  always @(posedge clk) begin
    if (dp_rst) begin
      dp_prod <= {32'b0, mplier};
      dp_c    <= 1'b0;
      dp_cnt  <= 0;
    end else begin
      if (add) {dp_c, dp_prod[63:32]} <= {1'b0, dp_prod[63:32]} + {1'b0, mcand};
      else if (shr) begin
        dp_prod <= {dp_c, dp_prod[63:1]};
        dp_c    <= 1'b0;
      end
      if (incr) dp_cnt <= dp_cnt + 1;
    end
  end

  assign write  = dp_prod[0];
  assign less32 = (force_iter >= 0 && dp_cnt >= force_iter) ? 1'b0 : (dp_cnt < WIDTH);

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-run observations
  int         dq[$];
  int         n_add, n_shr, n_busy, n_dprst;
  logic [6:0] snap;

  // Cycle 0 is the cycle before edge 0; start (if s1==0) is sampled at edge 0.
  // Inputs listed for cycle c are held during cycle c and sampled at its end.
  task automatic run(input logic [31:0] a, input logic [31:0] b,
                     input int s1, input int s2, input int s3, input int s4,
                     input int ab_at, input int rs_at, input int f_it,
                     input int snap_c, input int max_cyc);
    int cyc;
    mcand = a; mplier = b; force_iter = f_it;
    dq.delete();
    n_add = 0; n_shr = 0; n_busy = 0; n_dprst = 0; snap = '1;
    cyc = 0;
    start = (s1 == 0); abort = 1'b0; rst = 1'b0;
    while (cyc < max_cyc) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (done)   dq.push_back(cyc);
      if (add)    n_add++;
      if (shr)    n_shr++;
      if (busy)   n_busy++;
      if (dp_rst) n_dprst++;
      if (cyc == snap_c) snap = {dp_rst, add, shr, incr, busy, done, err};
      start = (cyc == s1) || (cyc == s2) || (cyc == s3) || (cyc == s4);
      abort = (cyc == ab_at);
      rst   = (cyc == rs_at);
    end
    start = 1'b0; abort = 1'b0; rst = 1'b0; force_iter = -1;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          exp_done;
    int          exp_adds;
  } vec_t;

  vec_t vecs[6];

  task automatic check_full_run(input vec_t v, input string tag);
    logic [63:0] prod_exp;
    prod_exp = 64'(v.a) * 64'(v.b);
    run(v.a, v.b, 0, -1, -1, -1, -1, -1, -1, 1, v.exp_done + 2);
    check({tag, " done_count"}, 64'(dq.size()), 64'd1);
    check({tag, " done_cycle"}, (dq.size() > 0) ? 64'(dq[0]) : '1, 64'(v.exp_done));
    check({tag, " adds"}, 64'(n_add), 64'(v.exp_adds));
    check({tag, " shifts"}, 64'(n_shr), 64'(WIDTH));
    check({tag, " busy_cycles"}, 64'(n_busy), 64'(v.exp_done - 1));
    check({tag, " init_outputs"}, 64'(snap), 64'(7'b1000100));
    check({tag, " product"}, dp_prod, prod_exp);
    check({tag, " err"}, 64'(err), 64'd0);
  endtask

  initial begin
    vec_t rv;
    vecs[0] = '{32'd11,        32'd14,        70, 3};
    vecs[1] = '{32'd5,         32'd0,         67, 0};
    vecs[2] = '{32'd7,         32'hFFFF_FFFF, 99, 32};
    vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 99, 32};
    vecs[4] = '{32'd1,         32'd1,         68, 1};
    vecs[5] = '{32'd3,         32'h8000_0000, 68, 1};

    // Reset for two cycles, then idle with all outputs low
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 64'({dp_rst, add, shr, incr, busy, done, err}), 64'd0);

    // less32 forced low at iter=5: err set, done the next cycle, err held in IDLE
    run(32'd11, 32'd14, 0, -1, -1, -1, -1, -1, 5, 16, 25);
    check("force done_count", 64'(dq.size()), 64'd1);
    check("force done_cycle", (dq.size() > 0) ? 64'(dq[0]) : '1, 64'd16);
    check("force done_outputs", 64'(snap), 64'(7'b0000011));
    check("force shifts", 64'(n_shr), 64'd5);
    check("force err_held", 64'(err), 64'd1);

    // Table vectors (the first also shows err cleared by the next start)
    for (int i = 0; i < 6; i++) check_full_run(vecs[i], $sformatf("vec%0d", i));

    // Starts at 10 and 67 ignored; start at 68 begins a second run
    run(32'd9, 32'd0, 0, 10, 67, 68, -1, -1, -1, 69, 137);
    check("restart done_count", 64'(dq.size()), 64'd2);
    check("restart first_done", (dq.size() > 0) ? 64'(dq[0]) : '1, 64'd67);
    check("restart second_done", (dq.size() > 1) ? 64'(dq[1]) : '1, 64'd135);
    check("restart dp_rst_count", 64'(n_dprst), 64'd2);
    check("restart init_outputs", 64'(snap), 64'(7'b1000100));
    check("restart adds", 64'(n_add), 64'd0);

    // Abort at cycle 20: IDLE in cycle 21, no done
    run(32'd11, 32'd14, 0, -1, -1, -1, 20, -1, -1, 21, 100);
    check("abort done_count", 64'(dq.size()), 64'd0);
    check("abort idle_outputs", 64'(snap), 64'd0);

    // Reset at cycle 30: IDLE in cycle 31, no done
    run(32'd11, 32'd14, 0, -1, -1, -1, -1, 30, -1, 31, 100);
    check("rst done_count", 64'(dq.size()), 64'd0);
    check("rst idle_outputs", 64'(snap), 64'd0);

    // Randomized operands against the arithmetic model
    for (int i = 0; i < 20; i++) begin
      rv.a        = $urandom;
      rv.b        = $urandom;
      if (i == 0) rv.b = rv.b & 32'h0000_00F0;
      rv.exp_done = 3 + 2 * WIDTH + $countones(rv.b);
      rv.exp_adds = $countones(rv.b);
      check_full_run(rv, $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
